// File: rtl/iro_meter_pkg.sv
// Shared types and constants for the ring-oscillator measurement engine.
// - iro_meter_state_t : measurement FSM states (IDLE, ARM, GATE)
// - ARM_CYCLES        : cycles spent in ARM so the synchroniser and the
//                       edge-detect register hold only the newly selected phase
package iro_meter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        GATE = 2'd2
    } iro_meter_state_t;

    localparam int ARM_CYCLES = 2;

endpackage

// File: rtl/iro_sync.sv
// Two-flop synchroniser applied bit-wise to an asynchronous bus.
// Ports:
//   clk  in  1  destination clock
//   rst  in  1  asynchronous, active-high reset (clears both stages)
//   d    in  W  asynchronous input bus
//   q    out W  bus resynchronised to clk (two cycles of latency)
module iro_sync #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/iro_meter.sv
// Measurement engine for the instrumented ring oscillator: resynchronises the
// phase bus, counts rising edges of one selected phase over a gate window and
// captures a phase snapshot at each window end (one-shot or continuous).
// Ports:
//   clk        in  1         system clock
//   rst        in  1         asynchronous, active-high reset
//   phases     in  N_PHASES  raw oscillator phases (asynchronous to clk)
//   start      in  1         level, acted on in IDLE only
//   abort      in  1         level, cancels any measurement (highest priority)
//   continuous in  1         re-arm windows back-to-back while high
//   sel        in  SEL_W     phase to count, latched at start
//   gate_len   in  GATE_W    window length in cycles (0 = 2^GATE_W)
//   busy       out 1         high in ARM and GATE
//   done       out 1         one-cycle pulse per completed window
//   count      out CNT_W     saturated edge count of the last window
//   overflow   out 1         last window saturated
//   snapshot   out N_PHASES  synchronised phases at the last window end
//   state      out           FSM state, for observation only
//
// Control protocol: start is a level that is taken on any clock edge where
// the FSM is in IDLE and abort is low; the result registers and the done
// pulse are the only completion indication, and done is never raised for a
// window cancelled by abort.
module iro_meter
    import iro_meter_pkg::*;
#(
    parameter int N_PHASES = 16,
    parameter int CNT_W    = 16,
    parameter int GATE_W   = 8,
    parameter int SEL_W    = $clog2(N_PHASES)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_PHASES-1:0] phases,
    input  logic                start,
    input  logic                abort,
    input  logic                continuous,
    input  logic [SEL_W-1:0]    sel,
    input  logic [GATE_W-1:0]   gate_len,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    count,
    output logic                overflow,
    output logic [N_PHASES-1:0] snapshot,
    output iro_meter_state_t    state
);

    localparam int               ARM_W    = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_CYCLES - 1);

    iro_meter_state_t    state_q, state_next;
    logic [N_PHASES-1:0] ph_s;
    logic                prev;
    logic [SEL_W-1:0]    sel_q;
    logic [GATE_W-1:0]   gate_q;
    logic [ARM_W-1:0]    arm_cnt;
    logic [CNT_W-1:0]    work_cnt;
    logic                work_ovf;

    logic                sel_bit, rise, cnt_max, sat_now, gate_last;
    logic [CNT_W-1:0]    cnt_inc;
    logic                accept, win_end;

    iro_sync #(.W(N_PHASES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (phases),
        .q   (ph_s)
    );

    assign sel_bit  = ph_s[sel_q];
    assign rise     = sel_bit & ~prev;
    assign cnt_max  = (work_cnt == '1);
    assign cnt_inc  = (rise && !cnt_max) ? work_cnt + CNT_W'(1) : work_cnt;
    assign sat_now  = rise && cnt_max;

    // gate_q is the remaining-cycle down-counter. A load of 0 first wraps to
    // all-ones, so it takes 2^GATE_W cycles to reach 1 (the last cycle).
    assign gate_last = (gate_q == GATE_W'(1));

    assign busy  = (state_q != IDLE);
    assign state = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    always_comb begin
        state_next = state_q;
        accept     = 1'b0;
        win_end    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    accept     = 1'b1;
                    state_next = ARM;
                end
            end
            ARM: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (arm_cnt == ARM_LAST) begin
                    state_next = GATE;
                end
            end
            GATE: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (gate_last) begin
                    win_end    = 1'b1;
                    state_next = continuous ? GATE : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev     <= 1'b0;
            sel_q    <= '0;
            gate_q   <= '0;
            arm_cnt  <= '0;
            work_cnt <= '0;
            work_ovf <= 1'b0;
            done     <= 1'b0;
            count    <= '0;
            overflow <= 1'b0;
            snapshot <= '0;
        end else begin
            prev    <= sel_bit;
            done    <= win_end;
            arm_cnt <= (state_q == ARM) ? arm_cnt + ARM_W'(1) : '0;
            if (accept) begin
                sel_q    <= sel;
                gate_q   <= gate_len;
                work_cnt <= '0;
                work_ovf <= 1'b0;
            end else if (win_end) begin
                // The last gate cycle's edge is folded straight into the result.
                count    <= cnt_inc;
                overflow <= work_ovf | sat_now;
                snapshot <= ph_s;
                work_cnt <= '0;
                work_ovf <= 1'b0;
                if (continuous) begin
                    gate_q <= gate_len;
                end
            end else if (state_q == GATE && !abort) begin
                work_cnt <= cnt_inc;
                work_ovf <= work_ovf | sat_now;
                gate_q   <= gate_q - GATE_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_iro_meter.sv
// Directed bench for iro_meter: square-wave phases driven on the falling
// clock edge, hand-derived latencies and counts, one checking task.
module tb_iro_meter;
    import iro_meter_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [15:0]      phases = '0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             continuous = 1'b0;
    logic [3:0]       sel = '0;
    logic [7:0]       gate_len = '0;

    logic             busy, done, overflow;
    logic [15:0]      count, snapshot;
    iro_meter_state_t state;

    logic             busy4, done4, overflow4;
    logic [3:0]       count4;
    logic [15:0]      snapshot4;
    iro_meter_state_t state4;

    int               per[16];
    int               tick = 0;
    int               cyc = 0;
    logic [15:0]      ph_at[4096];
    int               n_checks = 0;
    int               n_fail = 0;
    int               busy_low = 0;

    int               k, at, d, prev_at;
    logic [15:0]      exp_snap;

    iro_meter dut (
        .clk(clk), .rst(rst), .phases(phases), .start(start), .abort(abort),
        .continuous(continuous), .sel(sel), .gate_len(gate_len),
        .busy(busy), .done(done), .count(count), .overflow(overflow),
        .snapshot(snapshot), .state(state)
    );

    iro_meter #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .phases(phases), .start(start), .abort(abort),
        .continuous(continuous), .sel(sel), .gate_len(gate_len),
        .busy(busy4), .done(done4), .count(count4), .overflow(overflow4),
        .snapshot(snapshot4), .state(state4)
    );

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Phase generator: bit i is a square wave of period per[i] cycles.
    always @(negedge clk) begin
        tick = tick + 1;
        for (int i = 0; i < 16; i++) begin
            if (per[i] == 0) phases[i] = 1'b0;
            else             phases[i] = ((tick % per[i]) < (per[i] / 2));
        end
    end

    // Edge index and the phase value seen at every rising edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        ph_at[cyc & 4095] = phases;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives start for one cycle; k is the edge after which start was driven.
    task automatic do_start(input logic [3:0] s, input logic [7:0] g, input logic c, output int ks);
        @(posedge clk); #1;
        sel = s;
        gate_len = g;
        continuous = c;
        start = 1'b1;
        ks = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Returns the edge index of the next done pulse, or -1 if none in budget.
    task automatic wait_done(input bit use4, input int budget, output int at_o);
        at_o = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) busy_low++;
            if (use4 ? done4 : done) begin
                at_o = cyc;
                break;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) per[i] = 0;
        per[0]  = 4;
        per[3]  = 2;
        per[5]  = 6;
        per[9]  = 10;
        per[12] = 3;

        #1 rst = 1'b1;
        #6;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_count", count, 16'd0);
        check("rst_ovf", overflow, 1'b0);
        check("rst_snap", snapshot, 16'd0);
        check("rst_state", state, IDLE);
        check("rst_state4", state4, IDLE);
        @(negedge clk) rst = 1'b0;
        repeat (3) @(posedge clk);

        // One-shot, 16-cycle window, period 4 on phase 0.
        do_start(4'd0, 8'd16, 1'b0, k);
        check("t1_busy_arm", busy, 1'b1);
        check("t1_state_arm", state, ARM);
        wait_done(1'b0, 40, at);
        check("t1_latency", at - k, 19);
        check("t1_count", count, 16'd4);
        check("t1_ovf", overflow, 1'b0);
        check("t1_busy_done", busy, 1'b0);
        check("t1_snap", snapshot, ph_at[(at - 2) & 4095]);
        @(negedge clk);
        check("t1_done_pulse", done, 1'b0);

        // gate_len = 0 means a 256-cycle window.
        do_start(4'd0, 8'd0, 1'b0, k);
        wait_done(1'b0, 300, at);
        check("t2_latency", at - k, 259);
        check("t2_count", count, 16'd64);

        // 4-bit counter saturation on phase 3, then a clean window.
        do_start(4'd3, 8'd64, 1'b0, k);
        check("t3_busy4", busy4, 1'b1);
        wait_done(1'b1, 80, at);
        check("t3_latency4", at - k, 67);
        check("t3_count4", count4, 4'd15);
        check("t3_ovf4", overflow4, 1'b1);
        check("t3_wide_count", count, 16'd32);
        check("t3_snap4", snapshot4, ph_at[(at - 2) & 4095]);
        per[3] = 8;
        do_start(4'd3, 8'd16, 1'b0, k);
        wait_done(1'b1, 40, at);
        check("t3b_count4", count4, 4'd2);
        check("t3b_ovf4", overflow4, 1'b0);

        // Continuous windows of 8 cycles.
        do_start(4'd0, 8'd8, 1'b1, k);
        busy_low = 0;
        wait_done(1'b0, 20, at);
        check("t4_first_latency", at - k, 11);
        check("t4_first_count", count, 16'd2);
        check("t4_busy_done", busy, 1'b1);
        for (int w = 0; w < 3; w++) begin
            prev_at = at;
            wait_done(1'b0, 20, at);
            check("t4_period", at - prev_at, 8);
            check("t4_count", count, 16'd2);
        end
        check("t4_busy_constant", busy_low, 0);
        continuous = 1'b0;
        prev_at = at;
        wait_done(1'b0, 20, at);
        check("t4_last_period", at - prev_at, 8);
        check("t4_last_count", count, 16'd2);
        check("t4_last_busy", busy, 1'b0);
        exp_snap = ph_at[(at - 2) & 4095];
        check("t4_last_snap", snapshot, exp_snap);
        wait_done(1'b0, 20, at);
        check("t4_no_more_done", at, -1);

        // Abort during ARM.
        do_start(4'd0, 8'd16, 1'b0, k);
        check("t5_state_arm", state, ARM);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("t5_state_idle", state, IDLE);
        wait_done(1'b0, 40, at);
        check("t5_no_done", at, -1);
        check("t5_count_kept", count, 16'd2);
        check("t5_snap_kept", snapshot, exp_snap);

        // Abort in the last GATE cycle.
        do_start(4'd0, 8'd16, 1'b0, k);
        repeat (17) @(posedge clk);
        #1;
        check("t6_state_gate", state, GATE);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("t6_state_idle", state, IDLE);
        check("t6_done_low", done, 1'b0);
        wait_done(1'b0, 30, at);
        check("t6_no_done", at, -1);
        check("t6_count_kept", count, 16'd2);
        check("t6_ovf_kept", overflow, 1'b0);
        check("t6_snap_kept", snapshot, exp_snap);

        // Asynchronous reset in mid-GATE.
        do_start(4'd0, 8'd16, 1'b0, k);
        repeat (8) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("t7_rst_busy", busy, 1'b0);
        check("t7_rst_state", state, IDLE);
        check("t7_rst_count", count, 16'd0);
        check("t7_rst_snap", snapshot, 16'd0);
        check("t7_rst_done", done, 1'b0);
        #2 rst = 1'b0;

        // Fresh measurement; a start pulse while busy must be ignored.
        do_start(4'd0, 8'd16, 1'b0, k);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1;
        sel = 4'd5;
        gate_len = 8'd3;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(1'b0, 40, at);
        check("t8_latency", at - k, 19);
        check("t8_count", count, 16'd4);
        check("t8_snap", snapshot, ph_at[(at - 2) & 4095]);

        // start held in the done cycle launches the next one-shot.
        d = at;
        sel = 4'd0;
        gate_len = 8'd16;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(1'b0, 40, at);
        check("t9_b2b_latency", at - d, 19);
        check("t9_b2b_count", count, 16'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
